mul_wb_buffer: RTL and testbench

- Receiving end of the multiplier pipeline. Captures results from the last mul stage and buffers them in a small FIFO.
- Drains entries to the ROB/writeback port with a valid/ready handshake.
- Mul stages cannot stall, so a credit counter covering in-flight plus buffered ops back-pressures mul issue. This guarantees a result arriving from the last stage always has a free slot.

---
 rtl/mul_wb_buffer_pkg.sv | 35 +++
 rtl/mul_wb_fifo.sv | 62 ++++++
 rtl/mul_wb_buffer.sv | 143 ++++++++++++++
 tb/tb_mul_wb_buffer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_wb_buffer_pkg.sv
// Shared types and sizes for the multiplier writeback buffer.
package mul_wb_buffer_pkg;

   localparam int unsigned MUL_WB_DEPTH   = 8;
   localparam int unsigned THR_PER_CORE_W = 2;
   localparam int unsigned ROB_ID_W       = 6;
   localparam int unsigned PC_W           = 32;
   localparam int unsigned REG_ADDR_W     = 5;
   localparam int unsigned REG_DATA_W     = 32;

   typedef struct packed {
      logic misaligned;
      logic page_fault;
   } fetch_xcpt_t;

   typedef struct packed {
      logic illegal_instr;
   } decode_xcpt_t;

   typedef struct packed {
      logic overflow;
   } mul_xcpt_t;

   typedef struct packed {
      logic [THR_PER_CORE_W-1:0] thread_id;
      logic [ROB_ID_W-1:0]       instr_id;
      logic [PC_W-1:0]           program_counter;
      logic [REG_ADDR_W-1:0]     dest_reg;
      logic [REG_DATA_W-1:0]     data_result;
      fetch_xcpt_t               xcpt_fetch;
      decode_xcpt_t              xcpt_decode;
      mul_xcpt_t                 xcpt_mul;
   } mul_wb_entry_t;

endpackage

// File: rtl/mul_wb_fifo.sv
// Synchronous FIFO of writeback entries; head is read straight from storage.
// A push at full is accepted only alongside a pop; a pop at empty is ignored.
module mul_wb_fifo
   import mul_wb_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = MUL_WB_DEPTH,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                push,
   input  logic                pop,
   input  mul_wb_entry_t       wr_data,
   output mul_wb_entry_t       head,
   output logic                full,
   output logic                empty,
   output logic [PTR_W:0]      count
);

   localparam int unsigned CNT_W = PTR_W + 1;

   mul_wb_entry_t    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok_c;
   logic             pop_ok_c;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head      = mem_q[rd_ptr_q];
   assign pop_ok_c  = pop && !empty;
   assign push_ok_c = push && (!full || pop_ok_c);

   // Storage is cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
      end
   end

endmodule

// File: rtl/mul_wb_buffer.sv
// Multiplier writeback buffer: captures last-stage results, drains to the ROB,
// and back-pressures mul issue with credits. Optional flush: MUL_WB_FLUSH_EN.
module mul_wb_buffer
   import mul_wb_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = MUL_WB_DEPTH,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic                      clock,
   input  logic                      reset,
`ifdef MUL_WB_FLUSH_EN
   input  logic                      flush_in,
`endif
   input  logic                      mul_issue_in,
   input  logic [THR_PER_CORE_W-1:0] thread_id_in,
   input  logic                      instr_valid_in,
   input  logic [ROB_ID_W-1:0]       instr_id_in,
   input  logic [PC_W-1:0]           program_counter_in,
   input  logic [REG_ADDR_W-1:0]     dest_reg_in,
   input  logic [REG_DATA_W-1:0]     data_result_in,
   input  fetch_xcpt_t               xcpt_fetch_in,
   input  decode_xcpt_t              xcpt_decode_in,
   input  mul_xcpt_t                 xcpt_mul_in,
   output logic                      mul_stall_out,
   output logic                      rob_valid_out,
   input  logic                      rob_ready_in,
   output logic [THR_PER_CORE_W-1:0] rob_thread_id_out,
   output logic [ROB_ID_W-1:0]       rob_instr_id_out,
   output logic [PC_W-1:0]           rob_program_counter_out,
   output logic [REG_ADDR_W-1:0]     rob_dest_reg_out,
   output logic [REG_DATA_W-1:0]     rob_data_result_out,
   output fetch_xcpt_t               rob_xcpt_fetch_out,
   output decode_xcpt_t              rob_xcpt_decode_out,
   output mul_xcpt_t                 rob_xcpt_mul_out,
   output logic                      err_overflow_out
);

   localparam int unsigned      CNT_W        = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(DEPTH);

   logic             flush_c;
   logic             issue_c;
   logic             push_c;
   logic             pop_c;
   logic             push_drop_c;
   logic             fifo_full;
   logic             fifo_empty;
   logic [PTR_W:0]   fifo_count;
   mul_wb_entry_t    wr_entry_c;
   mul_wb_entry_t    head;
   logic [CNT_W-1:0] credits_q;
   logic [CNT_W-1:0] credits_d;
   logic             err_q;
   logic             err_d;

`ifdef MUL_WB_FLUSH_EN
   assign flush_c = flush_in;
`else
   assign flush_c = 1'b0;
`endif

   // Flush swallows any issue, push or pop in the same cycle.
   assign issue_c     = mul_issue_in && !flush_c;
   assign push_c      = instr_valid_in && !flush_c;
   assign pop_c       = rob_valid_out && rob_ready_in && !flush_c;
   assign push_drop_c = push_c && fifo_full && !pop_c;

   always_comb begin
      wr_entry_c                 = '0;
      wr_entry_c.thread_id       = thread_id_in;
      wr_entry_c.instr_id        = instr_id_in;
      wr_entry_c.program_counter = program_counter_in;
      wr_entry_c.dest_reg        = dest_reg_in;
      wr_entry_c.data_result     = data_result_in;
      wr_entry_c.xcpt_fetch      = xcpt_fetch_in;
      wr_entry_c.xcpt_decode     = xcpt_decode_in;
      wr_entry_c.xcpt_mul        = xcpt_mul_in;
   end

   mul_wb_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .clear   (flush_c),
      .push    (push_c),
      .pop     (pop_c),
      .wr_data (wr_entry_c),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Credits track in-flight plus buffered ops; issue at zero saturates.
   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      if (flush_c) begin
         credits_d = FULL_CREDITS;
      end else if (issue_c && !pop_c) begin
         if (credits_q != '0) begin
            credits_d = credits_q - CNT_W'(1);
         end
      end else if (pop_c && !issue_c) begin
         credits_d = credits_q + CNT_W'(1);
      end
      if ((issue_c && (credits_q == '0)) || push_drop_c) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         credits_q <= FULL_CREDITS;
         err_q     <= 1'b0;
      end else begin
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

   assign mul_stall_out           = (credits_q == '0);
   assign err_overflow_out        = err_q;
   assign rob_valid_out           = !fifo_empty;
   assign rob_thread_id_out       = head.thread_id;
   assign rob_instr_id_out        = head.instr_id;
   assign rob_program_counter_out = head.program_counter;
   assign rob_dest_reg_out        = head.dest_reg;
   assign rob_data_result_out     = head.data_result;
   assign rob_xcpt_fetch_out      = head.xcpt_fetch;
   assign rob_xcpt_decode_out     = head.xcpt_decode;
   assign rob_xcpt_mul_out        = head.xcpt_mul;

   // A pop can only return a credit that an earlier issue consumed.
   a_credit_bound: assert property (@(posedge clock) disable iff (reset)
      !(pop_c && !issue_c && (credits_q == FULL_CREDITS)));

   a_count_bound: assert property (@(posedge clock) disable iff (reset)
      (fifo_count <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Bench for mul_wb_buffer: directed scenarios plus randomized legal traffic,
// all checked against a queue-based model of the buffer.
module tb_mul_wb_buffer;
   import mul_wb_buffer_pkg::*;

   localparam int DEPTH = int'(MUL_WB_DEPTH);

   logic                      clock = 1'b0;
   logic                      reset = 1'b0;
   logic                      mul_issue_in = 1'b0;
   logic                      instr_valid_in = 1'b0;
   logic                      rob_ready_in = 1'b0;
`ifdef MUL_WB_FLUSH_EN
   logic                      flush_in = 1'b0;
`endif
   mul_wb_entry_t             in_e = '0;
   logic [THR_PER_CORE_W-1:0] rob_thread_id_out;
   logic [ROB_ID_W-1:0]       rob_instr_id_out;
   logic [PC_W-1:0]           rob_program_counter_out;
   logic [REG_ADDR_W-1:0]     rob_dest_reg_out;
   logic [REG_DATA_W-1:0]     rob_data_result_out;
   fetch_xcpt_t               rob_xcpt_fetch_out;
   decode_xcpt_t              rob_xcpt_decode_out;
   mul_xcpt_t                 rob_xcpt_mul_out;
   logic                      mul_stall_out;
   logic                      rob_valid_out;
   logic                      err_overflow_out;
   mul_wb_entry_t             act;

   always #5 clock = ~clock;

   mul_wb_buffer dut (
      .clock                   (clock),
      .reset                   (reset),
`ifdef MUL_WB_FLUSH_EN
      .flush_in                (flush_in),
`endif
      .mul_issue_in            (mul_issue_in),
      .thread_id_in            (in_e.thread_id),
      .instr_valid_in          (instr_valid_in),
      .instr_id_in             (in_e.instr_id),
      .program_counter_in      (in_e.program_counter),
      .dest_reg_in             (in_e.dest_reg),
      .data_result_in          (in_e.data_result),
      .xcpt_fetch_in           (in_e.xcpt_fetch),
      .xcpt_decode_in          (in_e.xcpt_decode),
      .xcpt_mul_in             (in_e.xcpt_mul),
      .mul_stall_out           (mul_stall_out),
      .rob_valid_out           (rob_valid_out),
      .rob_ready_in            (rob_ready_in),
      .rob_thread_id_out       (rob_thread_id_out),
      .rob_instr_id_out        (rob_instr_id_out),
      .rob_program_counter_out (rob_program_counter_out),
      .rob_dest_reg_out        (rob_dest_reg_out),
      .rob_data_result_out     (rob_data_result_out),
      .rob_xcpt_fetch_out      (rob_xcpt_fetch_out),
      .rob_xcpt_decode_out     (rob_xcpt_decode_out),
      .rob_xcpt_mul_out        (rob_xcpt_mul_out),
      .err_overflow_out        (err_overflow_out)
   );

   always_comb begin
      act                 = '0;
      act.thread_id       = rob_thread_id_out;
      act.instr_id        = rob_instr_id_out;
      act.program_counter = rob_program_counter_out;
      act.dest_reg        = rob_dest_reg_out;
      act.data_result     = rob_data_result_out;
      act.xcpt_fetch      = rob_xcpt_fetch_out;
      act.xcpt_decode     = rob_xcpt_decode_out;
      act.xcpt_mul        = rob_xcpt_mul_out;
   end

   // Model state: buffered entries in order, free credits, sticky error.
   mul_wb_entry_t mq[$];
   int            m_cred = DEPTH;
   bit            m_err  = 1'b0;
   int            n_vec  = 0;
   int            n_bad  = 0;
   mul_wb_entry_t z = '0;

   function automatic mul_wb_entry_t mk(input int id);
      mul_wb_entry_t e;
      e                           = '0;
      e.thread_id                 = THR_PER_CORE_W'(id);
      e.instr_id                  = ROB_ID_W'(id);
      e.program_counter           = PC_W'(32'h1000 + id * 4);
      e.dest_reg                  = REG_ADDR_W'(id + 1);
      e.data_result               = REG_DATA_W'(id * 17 + 5);
      e.xcpt_fetch.misaligned     = id[1];
      e.xcpt_fetch.page_fault     = id[2];
      e.xcpt_decode.illegal_instr = id[3];
      e.xcpt_mul.overflow         = id[0];
      return e;
   endfunction

   function automatic mul_wb_entry_t rnd_entry();
      mul_wb_entry_t e;
      e                           = '0;
      e.thread_id                 = THR_PER_CORE_W'($urandom);
      e.instr_id                  = ROB_ID_W'($urandom);
      e.program_counter           = PC_W'($urandom);
      e.dest_reg                  = REG_ADDR_W'($urandom);
      e.data_result               = REG_DATA_W'($urandom);
      e.xcpt_fetch                = fetch_xcpt_t'($urandom_range(0, 3));
      e.xcpt_decode               = decode_xcpt_t'($urandom_range(0, 1));
      e.xcpt_mul                  = mul_xcpt_t'($urandom_range(0, 1));
      return e;
   endfunction

   task automatic check_bit(input string name, input logic a, input logic e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, a, e, $time);
      end
   endtask

   task automatic check_int(input string name, input int a, input int e);
      n_vec++;
      if (a != e) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, a, e, $time);
      end
   endtask

   task automatic check_entry(input string name, input mul_wb_entry_t a, input mul_wb_entry_t e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
      end
   endtask

   task automatic compare();
      check_bit("rob_valid", rob_valid_out, mq.size() != 0);
      check_bit("mul_stall", mul_stall_out, m_cred == 0);
      check_bit("err_overflow", err_overflow_out, m_err);
      if (mq.size() != 0) check_entry("head", act, mq[0]);
   endtask

   // Drive one cycle from a negedge, advance the model, compare at the next negedge.
   task automatic step(input bit iss, input bit psh, input mul_wb_entry_t e,
                       input bit rdy, input bit fl);
      bit pop;
      bit was_full;
      mul_issue_in   = iss;
      instr_valid_in = psh;
      in_e           = e;
      rob_ready_in   = rdy;
`ifdef MUL_WB_FLUSH_EN
      flush_in       = fl;
`endif
      pop      = (mq.size() != 0) && rdy && !fl;
      was_full = (mq.size() == DEPTH);
      if (fl) begin
         mq.delete();
         m_cred = DEPTH;
      end else begin
         if (iss && m_cred == 0) m_err = 1'b1;
         if (pop) void'(mq.pop_front());
         if (psh) begin
            if (!was_full || pop) mq.push_back(e);
            else m_err = 1'b1;
         end
         if (iss && !pop) begin
            if (m_cred > 0) m_cred--;
         end else if (pop && !iss) begin
            m_cred++;
         end
      end
      @(posedge clock);
      @(negedge clock);
      compare();
   endtask

   task automatic do_reset();
      mul_issue_in   = 1'b0;
      instr_valid_in = 1'b0;
      rob_ready_in   = 1'b0;
      in_e           = '0;
`ifdef MUL_WB_FLUSH_EN
      flush_in       = 1'b0;
`endif
      reset = 1'b1;
      #1;
      check_bit("reset_valid", rob_valid_out, 1'b0);
      check_bit("reset_stall", mul_stall_out, 1'b0);
      check_bit("reset_err", err_overflow_out, 1'b0);
      check_entry("reset_head", act, z);
      mq.delete();
      m_cred = DEPTH;
      m_err  = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      mul_wb_entry_t e;
      bit p0;
      bit p1;
      bit iss;
      bit fl;
      int rdy_pct;

      #2;
      do_reset();

      // Single op: issue, push id 3 / 0x2A two cycles later, visible one cycle after push.
      step(1, 0, z, 1, 0);
      step(0, 0, z, 1, 0);
      e = '0;
      e.instr_id    = ROB_ID_W'(3);
      e.data_result = REG_DATA_W'(32'h2A);
      step(0, 1, e, 1, 0);
      check_bit("single_valid", rob_valid_out, 1'b1);
      check_int("single_id", int'(rob_instr_id_out), 3);
      check_int("single_data", int'(rob_data_result_out), 42);
      step(0, 0, z, 1, 0);
      check_bit("single_drained", rob_valid_out, 1'b0);
      check_bit("single_stall", mul_stall_out, 1'b0);

      // Back-pressure, full with simultaneous push/pop, in-order drain.
      do_reset();
      for (int i = 0; i < 8; i++) step(1, i >= 2, mk(i - 2), 0, 0);
      check_bit("bp_stall_after_8", mul_stall_out, 1'b1);
      step(0, 1, mk(6), 0, 0);
      step(0, 1, mk(7), 0, 0);
      check_int("full_head_id", int'(rob_instr_id_out), 0);
      step(0, 1, mk(8), 1, 0);
      check_bit("full_pushpop_err", err_overflow_out, 1'b0);
      check_bit("bp_stall_released", mul_stall_out, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         check_int("order_id", int'(rob_instr_id_out), k);
         step(k == 8, 0, z, 1, 0);
      end
      check_bit("order_empty", rob_valid_out, 1'b0);

      // Overflow by push at full without pop; contents intact, error sticky.
      do_reset();
      for (int i = 0; i < 10; i++) step(i < 8, i >= 2, mk(i - 2), 0, 0);
      check_bit("ovf_pre_err", err_overflow_out, 1'b0);
      step(0, 1, mk(99), 0, 0);
      check_bit("ovf_push_err", err_overflow_out, 1'b1);
      check_entry("ovf_head", act, mk(0));
      for (int k = 0; k < 8; k++) step(0, 0, z, 1, 0);
      check_bit("ovf_sticky", err_overflow_out, 1'b1);

      // Overflow by issue at zero credits.
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 0, z, 0, 0);
      check_bit("cred_zero_err", err_overflow_out, 1'b0);
      step(1, 0, z, 0, 0);
      check_bit("cred_issue_err", err_overflow_out, 1'b1);
      for (int i = 0; i < 3; i++) step(0, 0, z, 0, 0);
      check_bit("cred_sticky", err_overflow_out, 1'b1);

      // Head held stable under back-pressure.
      do_reset();
      step(1, 0, z, 0, 0);
      step(1, 0, z, 0, 0);
      step(0, 1, mk(20), 0, 0);
      step(0, 1, mk(21), 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, z, 0, 0);
         check_entry("hold_head", act, mk(20));
      end
      step(0, 0, z, 1, 0);
      check_entry("hold_next", act, mk(21));
      step(0, 0, z, 1, 0);

      // Reset mid-burst clears valid immediately.
      do_reset();
      step(1, 0, z, 0, 0);
      step(1, 0, z, 0, 0);
      step(1, 1, mk(30), 0, 0);
      step(0, 1, mk(31), 0, 0);
      step(0, 1, mk(32), 0, 0);
      do_reset();

`ifdef MUL_WB_FLUSH_EN
      // Flush coincident with a push empties the buffer and restores credits.
      step(1, 0, z, 0, 0);
      step(1, 0, z, 0, 0);
      step(1, 1, mk(40), 0, 0);
      step(0, 1, mk(41), 0, 0);
      step(0, 1, mk(42), 1, 1);
      check_bit("flush_valid", rob_valid_out, 1'b0);
      step(1, 0, z, 0, 1);
      for (int i = 0; i < 7; i++) step(1, 0, z, 0, 0);
      check_bit("flush_cred_7", mul_stall_out, 1'b0);
      step(1, 0, z, 0, 0);
      check_bit("flush_cred_8", mul_stall_out, 1'b1);
      do_reset();
`endif

      // Randomized legal traffic through a two-stage mul pipeline.
      p0      = 1'b0;
      p1      = 1'b0;
      rdy_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 100 == 0) rdy_pct = int'($urandom_range(5, 95));
         fl = 1'b0;
`ifdef MUL_WB_FLUSH_EN
         fl = ($urandom_range(0, 199) == 0);
`endif
         iss = (m_cred > 0) && !fl && ($urandom_range(0, 99) < 70);
         step(iss, p1, rnd_entry(), $urandom_range(0, 99) < rdy_pct, fl);
         p1 = fl ? 1'b0 : p0;
         p0 = fl ? 1'b0 : iss;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
